multiplexer: RTL and testbench

- 2:1 selector: output `w` carries `a` when `s`=0 and `b` when `s`=1.
- Combinational path for immediate use; registered copy for timing-clean downstream consumers.
- Housekeeping outputs: previous select, saturating count of select changes, input-equality flag.
- Leaf block used wherever a single-source choice between two data lanes is needed.

---
 rtl/multiplexer_pkg.sv | 12 +
 rtl/multiplexer_sel_toggle_counter.sv | 46 ++++
 rtl/multiplexer.sv | 73 +++++++
 tb/tb_multiplexer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/multiplexer_pkg.sv
// Shared constants for the multiplexer block: select encoding and default sizes.
package multiplexer_pkg;

    // Select encoding: SEL_A routes lane a, SEL_B routes lane b.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Default data width and toggle counter width.
    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 8;

endpackage : multiplexer_pkg

// File: rtl/multiplexer_sel_toggle_counter.sv
// Registers the select line and counts its transitions with a saturating counter.
// Counting starts only once the registered select holds a real post-reset sample.
module sel_toggle_counter
    import multiplexer_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    output logic             sel_q,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             sel_prev_q;
    logic             primed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: bump on a select change once primed, holding at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (primed_q && (s != sel_prev_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Select history, priming flag and counter state; reset wins over every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_prev_q <= SEL_A;
            primed_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sel_prev_q <= s;
            primed_q   <= 1'b1;
            cnt_q      <= cnt_d;
        end
    end

    assign sel_q      = sel_prev_q;
    assign toggle_cnt = cnt_q;

endmodule : sel_toggle_counter

// File: rtl/multiplexer.sv
// 2:1 data-lane selector with a combinational result, a registered copy and
// housekeeping status (previous select, select-change count, lane equality).
// Optional registered parity of the output is enabled by MULTIPLEXER_PARITY_EN.
module multiplexer
    import multiplexer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] w_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             a_eq_b
`ifdef MULTIPLEXER_PARITY_EN
    ,
    output logic             w_par
`endif
);

    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_reg_q;

    // Zero-latency lane selection and equality flag; neither depends on clk or rst.
    always_comb begin
        w_d    = (s == SEL_B) ? b : a;
        a_eq_b = (a == b);
    end

    assign w = w_d;

    // Timing-clean registered copy of the selected lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_reg_q <= '0;
        end else begin
            w_reg_q <= w_d;
        end
    end

    assign w_q = w_reg_q;

`ifdef MULTIPLEXER_PARITY_EN
    logic par_q;

    // Parity is taken from the combinational result so it lines up with w_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^w_d;
        end
    end

    assign w_par = par_q;
`endif

    sel_toggle_counter #(
        .CNT_W (CNT_W)
    ) u_sel_toggle_counter (
        .clk        (clk),
        .rst        (rst),
        .s          (s),
        .sel_q      (sel_q),
        .toggle_cnt (toggle_cnt)
    );

endmodule : multiplexer

// File: tb/tb_multiplexer.sv
// Directed self-checking bench for multiplexer: one 4-bit instance with an
// 8-bit counter and one 1-bit instance with a 2-bit counter for saturation.
module tb_multiplexer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: WIDTH=4, CNT_W=8
    logic       rst;
    logic [3:0] a, b;
    logic       s;
    logic [3:0] w, w_q;
    logic       sel_q;
    logic [7:0] toggle_cnt;
    logic       a_eq_b;

    // Saturation instance: WIDTH=1, CNT_W=2
    logic       rst2;
    logic       a2, b2, s2;
    logic       w2, w_q2;
    logic       sel_q2;
    logic [1:0] toggle_cnt2;
    logic       a_eq_b2;

`ifdef MULTIPLEXER_PARITY_EN
    logic w_par, w_par2;
`endif

    int checks = 0;
    int errors = 0;

    multiplexer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .s          (s),
        .w          (w),
        .w_q        (w_q),
        .sel_q      (sel_q),
        .toggle_cnt (toggle_cnt),
        .a_eq_b     (a_eq_b)
`ifdef MULTIPLEXER_PARITY_EN
        ,
        .w_par      (w_par)
`endif
    );

    multiplexer #(.WIDTH(1), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst2),
        .a          (a2),
        .b          (b2),
        .s          (s2),
        .w          (w2),
        .w_q        (w_q2),
        .sel_q      (sel_q2),
        .toggle_cnt (toggle_cnt2),
        .a_eq_b     (a_eq_b2)
`ifdef MULTIPLEXER_PARITY_EN
        ,
        .w_par      (w_par2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a = 4'h5; b = 4'hA; s = 1'b0;
        rst2 = 1'b1; a2 = 1'b0; b2 = 1'b1; s2 = 1'b0;

        // Reset held two cycles while s toggles; w keeps tracking inputs.
        tick();
        s = 1'b1; #1;
        check("w_during_rst", 32'(w), 32'hA);
        tick();
        check("rst_w_q", 32'(w_q), 32'h0);
        check("rst_sel_q", 32'(sel_q), 32'h0);
        check("rst_cnt", 32'(toggle_cnt), 32'h0);
`ifdef MULTIPLEXER_PARITY_EN
        check("rst_w_par", 32'(w_par), 32'h0);
`endif

        // First post-reset edge with s=1 against sel_q=0 must not count.
        rst = 1'b0; a = 4'h0; b = 4'h0; s = 1'b1; #1;
        check("eq00_w", 32'(w), 32'h0);
        check("eq00_a_eq_b", 32'(a_eq_b), 32'h1);
        tick();
        check("prime_sel_q", 32'(sel_q), 32'h1);
        check("prime_cnt", 32'(toggle_cnt), 32'h0);
        check("eq00_w_q", 32'(w_q), 32'h0);
        $display("step prime: sel_q=%0d cnt=%0d w_q=%0h", sel_q, toggle_cnt, w_q);

        // a==b: w ignores s; the s change counts once.
        a = 4'h1; b = 4'h1; s = 1'b1; #1;
        check("eq11_w_s1", 32'(w), 32'h1);
        check("eq11_a_eq_b", 32'(a_eq_b), 32'h1);
        tick();
        check("eq11_cnt_hold", 32'(toggle_cnt), 32'h0);
        s = 1'b0; #1;
        check("eq11_w_s0", 32'(w), 32'h1);
        tick();
        check("eq11_cnt_inc", 32'(toggle_cnt), 32'h1);
        check("eq11_sel_q", 32'(sel_q), 32'h0);
        check("eq11_w_q", 32'(w_q), 32'h1);
        $display("step eq11: w_q=%0h cnt=%0d", w_q, toggle_cnt);

        // Distinct lanes: switch s and see w change at once, w_q a cycle later.
        a = 4'h1; b = 4'h0; s = 1'b0; #1;
        check("ne_w_a", 32'(w), 32'h1);
        check("ne_a_eq_b", 32'(a_eq_b), 32'h0);
        tick();
        check("ne_w_q_a", 32'(w_q), 32'h1);
        check("ne_cnt_same", 32'(toggle_cnt), 32'h1);
        s = 1'b1; #1;
        check("ne_w_b", 32'(w), 32'h0);
        check("ne_w_q_lag", 32'(w_q), 32'h1);
        tick();
        check("ne_w_q_b", 32'(w_q), 32'h0);
        check("ne_cnt", 32'(toggle_cnt), 32'h2);
        $display("step ne: w_q=%0h cnt=%0d", w_q, toggle_cnt);

        // Wider patterns and parity of the registered result.
        a = 4'h7; b = 4'hC; s = 1'b0; #1;
        check("wide_w_a", 32'(w), 32'h7);
        tick();
        check("wide_w_q_a", 32'(w_q), 32'h7);
        check("wide_cnt3", 32'(toggle_cnt), 32'h3);
`ifdef MULTIPLEXER_PARITY_EN
        check("wide_par_a", 32'(w_par), 32'h1);
`endif
        s = 1'b1; #1;
        check("wide_w_b", 32'(w), 32'hC);
        tick();
        check("wide_w_q_b", 32'(w_q), 32'hC);
        check("wide_cnt4", 32'(toggle_cnt), 32'h4);
`ifdef MULTIPLEXER_PARITY_EN
        check("wide_par_b", 32'(w_par), 32'h0);
`endif
        $display("step wide: w_q=%0h cnt=%0d", w_q, toggle_cnt);

        // Mid-operation reset clears state on that edge; w still tracks inputs.
        rst = 1'b1; s = 1'b0;
        tick();
        check("mid_rst_w_q", 32'(w_q), 32'h0);
        check("mid_rst_sel_q", 32'(sel_q), 32'h0);
        check("mid_rst_cnt", 32'(toggle_cnt), 32'h0);
        check("mid_rst_w", 32'(w), 32'h7);
        rst = 1'b0;
        $display("step mid_rst: w=%0h w_q=%0h cnt=%0d", w, w_q, toggle_cnt);

        // Saturation on the 2-bit counter: prime with s2=0, then toggle each cycle.
        rst2 = 1'b0; s2 = 1'b0;
        tick();
        check("sat_prime_cnt", 32'(toggle_cnt2), 32'h0);
        for (int i = 1; i <= 6; i++) begin
            s2 = ~s2;
            tick();
            check($sformatf("sat_cnt_%0d", i), 32'(toggle_cnt2), (i < 3) ? 32'(i) : 32'h3);
            check($sformatf("sat_w_q_%0d", i), 32'(w_q2), 32'(s2 ? b2 : a2));
            $display("step sat %0d: s=%0d cnt=%0d", i, s2, toggle_cnt2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_multiplexer
